// File: rtl/i2s_tx_out.sv
// Output stage: captures filtered samples and serialises them MSB-first onto a 3-wire DAC link.
// Default build is left-justified; defining I2S_DELAY_EN selects Philips I2S (one-sclk data delay).
module i2s_tx_out #(
    parameter int DATA_SIZE  = 24,
    parameter int FRAME_BITS = 32,
    parameter int SCLK_DIV   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_SIZE-1:0] data_in,
    input  logic                 data_valid,
    output logic                 sclk,
    output logic                 lrclk,
    output logic                 sdata,
    output logic                 overrun
);

    localparam int CW = $clog2(2 * FRAME_BITS);
    localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [CW-1:0] LAST_BIT  = CW'(2 * FRAME_BITS - 1);
    localparam logic [CW-1:0] SLOT_BITS = CW'(FRAME_BITS);
    localparam logic [CW-1:0] DATA_BITS = CW'(DATA_SIZE);
    localparam logic [DW-1:0] DIV_LAST  = DW'(SCLK_DIV - 1);

    logic [DW-1:0]        r_divCnt;
    logic                 r_sclk;
    logic [CW-1:0]        r_bitCnt;
    logic                 r_lrclk;
    logic                 r_sdata;
    logic                 r_overrun;
    logic [DATA_SIZE-1:0] r_holdReg;
    logic [DATA_SIZE-1:0] r_frameReg;
    logic                 r_pending;

    logic                 w_divWrap;
    logic                 w_shift;
    logic                 w_frameStart;
    logic [CW-1:0]        w_bitCntNext;
    logic [CW-1:0]        w_slotBit;
    logic [CW-1:0]        w_shiftAmt;
    logic [DATA_SIZE-1:0] w_frameNext;
    logic [DATA_SIZE-1:0] w_frameData;
    logic [DATA_SIZE-1:0] w_shifted;
    logic                 w_bitEn;
    logic                 w_lrclkNext;
    logic                 w_sdataNext;

    // Slot outputs are computed from the post-shift bit count so they move together with sclk falling.
    always_comb begin
        w_divWrap    = (r_divCnt == DIV_LAST);
        w_shift      = w_divWrap && r_sclk;
        w_frameStart = w_shift && (r_bitCnt == LAST_BIT);
        w_bitCntNext = (r_bitCnt == LAST_BIT) ? '0 : r_bitCnt + 1'b1;
        w_slotBit    = (w_bitCntNext >= SLOT_BITS) ? w_bitCntNext - SLOT_BITS : w_bitCntNext;

        // A strobe coinciding with frame start bypasses the holding register.
        if (data_valid) begin
            w_frameNext = data_in;
        end else if (r_pending) begin
            w_frameNext = r_holdReg;
        end else begin
            w_frameNext = r_frameReg;
        end
        w_frameData = w_frameStart ? w_frameNext : r_frameReg;

`ifdef I2S_DELAY_EN
        w_lrclkNext = (w_bitCntNext >= SLOT_BITS - 1'b1) && (w_bitCntNext != LAST_BIT);
        w_bitEn     = (w_slotBit != '0) && (w_slotBit <= DATA_BITS);
        w_shiftAmt  = w_slotBit - 1'b1;
`else
        w_lrclkNext = (w_bitCntNext >= SLOT_BITS);
        w_bitEn     = (w_slotBit < DATA_BITS);
        w_shiftAmt  = w_slotBit;
`endif
        w_shifted   = w_frameData << w_shiftAmt;
        w_sdataNext = w_bitEn && w_shifted[DATA_SIZE-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_divCnt   <= '0;
            r_sclk     <= 1'b0;
            r_bitCnt   <= LAST_BIT;
            r_lrclk    <= 1'b1;
            r_sdata    <= 1'b0;
            r_overrun  <= 1'b0;
            r_holdReg  <= '0;
            r_frameReg <= '0;
            r_pending  <= 1'b0;
        end else begin
            r_divCnt  <= w_divWrap ? '0 : r_divCnt + 1'b1;
            r_overrun <= data_valid && r_pending && !w_frameStart;
            if (w_divWrap) begin
                r_sclk <= ~r_sclk;
            end
            if (data_valid) begin
                r_holdReg <= data_in;
            end
            if (w_frameStart) begin
                r_pending <= 1'b0;
            end else if (data_valid) begin
                r_pending <= 1'b1;
            end
            if (w_shift) begin
                r_bitCnt <= w_bitCntNext;
                r_lrclk  <= w_lrclkNext;
                r_sdata  <= w_sdataNext;
                if (w_frameStart) begin
                    r_frameReg <= w_frameNext;
                end
            end
        end
    end

    assign sclk    = r_sclk;
    assign lrclk   = r_lrclk;
    assign sdata   = r_sdata;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_i2s_tx_out.sv
// Scoreboard bench for i2s_tx_out: stimulus pushes per-frame expectations, a monitor decodes the serial link.
module tb_i2s_tx_out;

    localparam int DS        = 24;
    localparam int F         = 32;
    localparam int SD        = 2;
    localparam int FRAME_CYC = 4 * SD * F;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          data_valid = 1'b0;
    logic [DS-1:0] data_in = '0;
    logic          sclk;
    logic          lrclk;
    logic          sdata;
    logic          overrun;

    i2s_tx_out #(.DATA_SIZE(DS), .FRAME_BITS(F), .SCLK_DIV(SD)) dut (
        .clk(clk),
        .reset(reset),
        .data_in(data_in),
        .data_valid(data_valid),
        .sclk(sclk),
        .lrclk(lrclk),
        .sdata(sdata),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // cyc equals the number of clk edges since the edge that sampled reset
    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    logic [DS-1:0] expFrameQ[$];
    int            expOvrQ[$];
    logic [DS-1:0] modelVal = '0;
    int            winIdx = 0;
    bit            stimDone = 1'b0;
    int            planN = 0;
    int            planOff[3];
    logic [DS-1:0] planVal[3];

    bit            rstChecked = 1'b0;
    bit            frameActive = 1'b0;
    int            ovrCnt = 0;
    int            clkErr = 0;
    logic          lastSdata = 1'b0;
    logic [2*F-1:0] capWord = '0;
    logic [2*F-1:0] expWord = '0;

    function automatic logic [2*F-1:0] frameWord(input logic [DS-1:0] v);
        logic [F-1:0] slot;
`ifdef I2S_DELAY_EN
        slot = F'(v) << (F - DS - 1);
`else
        slot = F'(v) << (F - DS);
`endif
        return {slot, slot};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic setPlan(input int n, input int o0, input logic [DS-1:0] v0,
                           input int o1, input logic [DS-1:0] v1);
        planN = n;
        planOff[0] = o0; planVal[0] = v0;
        planOff[1] = o1; planVal[1] = v1;
        planOff[2] = 0;  planVal[2] = '0;
    endtask

    task automatic randomPlan();
        int seg;
        seg = FRAME_CYC / 3;
        planN = $urandom_range(0, 3);
        for (int j = 0; j < planN; j++) begin
            planOff[j] = j * seg + $urandom_range(1, seg);
            planVal[j] = DS'($urandom);
        end
        if (planN > 0 && $urandom_range(0, 3) == 0) planOff[planN-1] = FRAME_CYC;
    endtask

    // One window = the clk edges up to and including the next frame start; the last strobe wins
    // and every early strobe after the first is an overrun.
    task automatic applyStimulus(input int abortAt);
        int len;
        int nEarly;
        len = (winIdx == 0) ? 2 * SD : FRAME_CYC;
        if (abortAt == 0) begin
            nEarly = 0;
            for (int j = 0; j < planN; j++) if (planOff[j] < len) nEarly++;
            if (planN > 0) modelVal = planVal[planN-1];
            expFrameQ.push_back(modelVal);
            expOvrQ.push_back(nEarly > 1 ? nEarly - 1 : 0);
        end
        for (int c = 1; c <= len; c++) begin
            if (abortAt != 0 && c == abortAt) begin
                data_valid = 1'b0;
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                modelVal = '0;
                winIdx = 0;
                return;
            end
            data_valid = 1'b0;
            for (int j = 0; j < planN; j++) begin
                if (planOff[j] == c) begin
                    data_valid = 1'b1;
                    data_in = planVal[j];
                end
            end
            @(negedge clk);
        end
        data_valid = 1'b0;
        winIdx++;
    endtask

    // Monitor: expected waveform derived from cycle arithmetic; sample values from the scoreboard
    always @(negedge clk) begin : monitor
        int n;
        int e;
        int bc;
        logic expSclk;
        logic expLr;
        logic [DS-1:0] v;
        n = cyc;
        if (n == 0) begin
            if (!rstChecked) begin
                checkOutput("reset_sclk", 64'(sclk), 64'd0);
                checkOutput("reset_lrclk", 64'(lrclk), 64'd1);
                checkOutput("reset_sdata", 64'(sdata), 64'd0);
                checkOutput("reset_overrun", 64'(overrun), 64'd0);
                rstChecked = 1'b1;
            end
            frameActive = 1'b0;
            ovrCnt = 0;
            clkErr = 0;
            lastSdata = 1'b0;
        end else begin
            rstChecked = 1'b0;
            e = n / (2 * SD);
            bc = (e > 0) ? (e - 1) % (2 * F) : 2 * F - 1;
            expSclk = ((n / SD) % 2) == 1;
            if (e == 0) begin
                expLr = 1'b1;
            end else begin
`ifdef I2S_DELAY_EN
                expLr = ((bc + 1) % (2 * F)) >= F;
`else
                expLr = bc >= F;
`endif
            end
            if (sclk !== expSclk || lrclk !== expLr) clkErr++;
            if ((n % (2 * SD)) != 0 && sdata !== lastSdata) clkErr++;
            if (overrun === 1'b1) ovrCnt++;
            if ((n % (2 * SD)) == 0 && e > 0) begin
                if (bc == 0) begin
                    frameActive = 1'b0;
                    if (!stimDone) begin
                        if (expFrameQ.size() == 0 || expOvrQ.size() == 0) begin
                            tests++;
                            fails++;
                            $display("[TB] FAIL frame_queue actual=empty required=entry at cycle %0d", n);
                        end else begin
                            v = expFrameQ.pop_front();
                            checkOutput("overrun_count", 64'(ovrCnt), 64'(expOvrQ.pop_front()));
                            expWord = frameWord(v);
                            capWord = '0;
                            frameActive = 1'b1;
                        end
                    end
                    ovrCnt = 0;
                end
                capWord[2*F-1-bc] = sdata;
                if (bc == 2 * F - 1) begin
                    if (frameActive) begin
                        checkOutput("frame_bits", capWord, expWord);
                        checkOutput("clock_shape_errors", 64'(clkErr), 64'd0);
                    end
                    frameActive = 1'b0;
                    clkErr = 0;
                end
            end
            lastSdata = sdata;
        end
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        setPlan(1, 1, 24'hA5F00F, 0, '0);
        applyStimulus(0);
        setPlan(0, 0, '0, 0, '0);
        applyStimulus(0);
        setPlan(2, 30, 24'h000001, 100, 24'h800000);
        applyStimulus(0);
        setPlan(2, 50, 24'h123456, FRAME_CYC, 24'h7FFFFF);
        applyStimulus(0);
        repeat (10) begin
            randomPlan();
            applyStimulus(0);
        end

        setPlan(1, 5, DS'($urandom), 0, '0);
        applyStimulus(41);
        setPlan(0, 0, '0, 0, '0);
        applyStimulus(0);
        applyStimulus(0);
        repeat (4) begin
            randomPlan();
            applyStimulus(0);
        end

        setPlan(0, 0, '0, 0, '0);
        repeat (FRAME_CYC - 2) @(negedge clk);
        stimDone = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("queue_drained", 64'(expFrameQ.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/i2s_tx_out.md
Name: i2s_tx_out

Overview:
- Output stage placed directly after the high-pass filter top.
- Captures each filtered sample on the filter's completion pulse, holds it in a single holding register, and serialises it MSB-first onto a left-justified, I2S-style 3-wire DAC interface.
- Generates its own bit clock (sclk) and word clock (lrclk) from the system clock.
- Mono source: the same sample is sent in both the left and right channel slots.

Parameters:
- DATA_SIZE, 24, sample width in bits; must match the filter's data width.
- FRAME_BITS, 32, sclk periods per channel slot; must be >= DATA_SIZE.
- SCLK_DIV, 2, clk cycles per sclk half-period; must be >= 1.

Ports:
- clk, input, 1, system clock; all logic is on the rising edge.
- reset, input, 1, synchronous, active-high reset.
- data_in, input, DATA_SIZE, filtered sample; connects to the filter's data_out.
- data_valid, input, 1, one-cycle strobe meaning data_in is valid; connects to the filter's filter_end.
- sclk, output, 1, serial bit clock.
- lrclk, output, 1, word select: 0 = left slot, 1 = right slot.
- sdata, output, 1, serial data, MSB-first.
- overrun, output, 1, one-cycle pulse: a pending sample was overwritten before it was sent.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - Outputs: sclk=0, lrclk=1, sdata=0, overrun=0.
  - Internal: div_cnt=0, bit_cnt=2*FRAME_BITS-1, hold_reg=0, frame_reg=0, pending=0.
  - Reset asserted mid-frame aborts the frame and discards any pending sample; every output shows its reset value on the cycle after reset is sampled.
- Divider:
  - div_cnt counts 0..SCLK_DIV-1.
  - On wrap, sclk toggles.
  - A 1->0 toggle of sclk is a "shift event". All other outputs change only on shift events, on the same clk edge as sclk falls.
- Bit counter:
  - bit_cnt increments on each shift event, wrapping from 2*FRAME_BITS-1 to 0.
  - A wrap to 0 is a "frame start".
  - The first frame start after reset is at clk cycle 2*SCLK_DIV.
- Slot outputs, with k = bit_cnt mod FRAME_BITS:
  - lrclk = (bit_cnt >= FRAME_BITS).
  - sdata = frame_reg[DATA_SIZE-1-k] when k < DATA_SIZE, else 0.
- Capture:
  - On data_valid: hold_reg <= data_in and pending <= 1.
  - If pending was already 1 and the cycle is not a frame start, overrun=1 for exactly that cycle; the newer sample wins.
- Frame load, at frame start:
  - If pending: frame_reg <= hold_reg and pending <= 0.
  - Otherwise frame_reg keeps its value, so the last sample repeats.
  - sdata on that edge already carries the new frame_reg MSB.
- Data_valid on the same cycle as a frame start: data_in goes directly into frame_reg and is sent in this frame. pending ends at 0 and overrun stays 0, even if an older sample was pending; that older sample is silently dropped.
- Latency: a sample accepted before a frame start has its MSB on sdata at that frame start. Worst case is 2*FRAME_BITS*2*SCLK_DIV clk cycles.
- No backpressure to the filter. The system sample rate must not exceed clk / (4*SCLK_DIV*FRAME_BITS).

Optional Feature:
- Macro: I2S_DELAY_EN.
- When defined, the output is Philips I2S format:
  - lrclk changes one shift event before the slot's MSB, i.e. lrclk = ((bit_cnt+1) mod 2*FRAME_BITS) >= FRAME_BITS.
  - The sdata bit index is delayed one sclk, k' = k-1. k = 0 outputs the previous slot's trailing 0.
  - Frame-load timing is unchanged.
- When not defined, the output is the left-justified format described above.

Test Plan:
1. Reset, defaults (SCLK_DIV=2, FRAME_BITS=32) -> sclk=0, lrclk=1, sdata=0, overrun=0; sclk rises at cycle 2, falls at cycle 4; lrclk goes 0 at cycle 4.
2. data_valid with data_in=24'hA5F00F at cycle 1 -> frame starting cycle 4 carries bits 1010_0101_1111_0000_0000_1111 then 8 zeros in the left slot, the same 32 bits in the right slot; frame is 256 clk long.
3. No further data_valid -> the frame starting at cycle 260 repeats 24'hA5F00F in both slots.
4. data_valid with 24'h000001 then with 24'h800000, both inside one frame -> overrun=1 for one cycle on the second strobe; next frame sends 800000 (bit 1 then 31 zeros per slot).
5. data_valid with 24'h7FFFFF exactly on a frame-start cycle -> this frame sends 7FFFFF (0 then 23 ones then 8 zeros per slot); overrun stays 0.
6. reset asserted at bit 10 of the left slot with a sample pending -> next cycle all outputs and state at reset values; after release, frames send 0 until a new data_valid.
